// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by seq_alu and seq_muldiv.
//   - ALU control opcodes, four bits wide, matching the datapath decoder.
//   - FSM state encoding for the sequencing controller.
//   - is_muldiv(): true for the opcodes that take the iterative path.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_MUL  = 4'b1001;
  localparam logic [3:0] ALU_DIVU = 4'b1010;
  localparam logic [3:0] ALU_REMU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative multiplier / restoring divider, one bit per cycle.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   start         load operands and begin a WIDTH-step operation
//   op            ALU_MUL, ALU_DIVU or ALU_REMU (sampled with start)
//   a, b          operand A (multiplicand / dividend), B (multiplier / divisor)
//   done          one-cycle pulse once all WIDTH steps have been taken
//   result        low product, quotient or remainder; valid while done
// Latency is fixed at WIDTH step cycles plus the done cycle, independent
// of the operand values.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Register roles:
  //   MUL : acc = partial product, x = shifted multiplicand, y = shifted multiplier
  //   DIV : acc = partial remainder, x = dividend shifting into quotient, y = divisor
  logic             busy_reg;
  logic [CNT_W-1:0] count_reg;
  logic             mul_reg;
  logic             rem_reg;
  logic [WIDTH-1:0] acc_reg,  acc_next;
  logic [WIDTH-1:0] x_reg,    x_next;
  logic [WIDTH-1:0] y_reg,    y_next;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  always_comb begin
    trial    = {acc_reg, x_reg[WIDTH-1]};
    diff     = trial - {1'b0, y_reg};
    acc_next = acc_reg;
    x_next   = x_reg;
    y_next   = y_reg;
    if (mul_reg) begin
      acc_next = y_reg[0] ? (acc_reg + x_reg) : acc_reg;
      x_next   = {x_reg[WIDTH-2:0], 1'b0};
      y_next   = {1'b0, y_reg[WIDTH-1:1]};
    end else begin
      // Restoring step. A zero divisor always "fits", which naturally
      // yields an all-ones quotient and leaves the dividend as remainder.
      if (trial >= {1'b0, y_reg}) begin
        acc_next = diff[WIDTH-1:0];
        x_next   = {x_reg[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = trial[WIDTH-1:0];
        x_next   = {x_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_reg  <= 1'b0;
      count_reg <= '0;
      mul_reg   <= 1'b0;
      rem_reg   <= 1'b0;
      acc_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
    end else if (start) begin
      busy_reg  <= 1'b1;
      count_reg <= CNT_W'(WIDTH);
      mul_reg   <= (op == ALU_MUL);
      rem_reg   <= (op == ALU_REMU);
      acc_reg   <= '0;
      x_reg     <= a;
      y_reg     <= b;
    end else if (busy_reg) begin
      if (count_reg != '0) begin
        acc_reg   <= acc_next;
        x_reg     <= x_next;
        y_reg     <= y_next;
        count_reg <= count_reg - CNT_W'(1);
      end else begin
        // done is seen for exactly this cycle; drop busy afterwards
        busy_reg <= 1'b0;
      end
    end
  end

  assign done   = busy_reg && (count_reg == '0);
  assign result = (mul_reg || rem_reg) ? acc_reg : x_reg;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked execute-stage ALU with registered result and flags.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   operation request handshake (ready only when idle)
//   ALUControl            opcode (see alu_pkg)
//   input1, input2        operands A and B, latched on acceptance
//   out_valid / out_ready result handshake; outputs held until consumed
//   ALUOut                registered result
//   zero                  ALUOut == 0, registered with the result
//   overflow              signed overflow for ADD/SUB, else 0
// Simple ops finish one cycle after acceptance; MUL/DIVU/REMU take
// WIDTH+1 cycles through seq_muldiv.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  ALUControl,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUOut,
  output logic             zero,
  output logic             overflow
);

  localparam int SH_W = $clog2(WIDTH);

  state_t           state_reg;
  logic [OP_W-1:0]  op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             ovf_reg;

  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  logic [WIDTH-1:0] simple_result;
  logic             simple_ovf;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [SH_W-1:0]  shamt;

  assign accept   = (state_reg == S_IDLE) && in_valid;
  assign md_start = accept && is_muldiv(ALUControl);

  seq_muldiv #(
    .WIDTH (WIDTH),
    .OP_W  (OP_W)
  ) u_muldiv (
    .clock  (clock),
    .reset  (reset),
    .start  (md_start),
    .op     (ALUControl),
    .a      (input1),
    .b      (input2),
    .done   (md_done),
    .result (md_result)
  );

  // Single-cycle ops, evaluated from the latched operands during BUSY.
  always_comb begin
    sum           = a_reg + b_reg;
    dif           = a_reg - b_reg;
    shamt         = b_reg[SH_W-1:0];
    simple_result = '0;
    simple_ovf    = 1'b0;
    case (op_reg)
      ALU_AND:  simple_result = a_reg & b_reg;
      ALU_OR:   simple_result = a_reg | b_reg;
      ALU_NOR:  simple_result = ~(a_reg | b_reg);
      ALU_ADD: begin
        simple_result = sum;
        simple_ovf    = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (sum[WIDTH-1] != a_reg[WIDTH-1]);
      end
      ALU_SUB: begin
        simple_result = dif;
        simple_ovf    = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                        (dif[WIDTH-1] != a_reg[WIDTH-1]);
      end
      ALU_SLT:  simple_result = {{(WIDTH-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
      ALU_SLTU: simple_result = {{(WIDTH-1){1'b0}}, (a_reg < b_reg)};
      ALU_SLL:  simple_result = a_reg << shamt;
      ALU_SRL:  simple_result = a_reg >> shamt;
      ALU_SRA:  simple_result = WIDTH'($signed(a_reg) >>> shamt);
      default:  simple_result = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            op_reg    <= ALUControl;
            a_reg     <= input1;
            b_reg     <= input2;
            state_reg <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!is_muldiv(op_reg)) begin
            result_reg <= simple_result;
            zero_reg   <= (simple_result == '0);
            ovf_reg    <= simple_ovf;
            state_reg  <= S_DONE;
          end else if (md_done) begin
            result_reg <= md_result;
            zero_reg   <= (md_result == '0);
            ovf_reg    <= 1'b0;
            state_reg  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);
  assign ALUOut    = result_reg;
  assign zero      = zero_reg;
  assign overflow  = ovf_reg;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (WIDTH=32). Expected results are
// pushed when an operation is accepted and popped when out_valid appears.
module tb_seq_alu;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ALUControl;
  logic [W-1:0] input1;
  logic [W-1:0] input2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUOut;
  logic         zero;
  logic         overflow;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] r;
    logic         z;
    logic         v;
    int           lat;
  } exp_t;

  exp_t sb[$];

  seq_alu #(.WIDTH(W), .OP_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .input1     (input1),
    .input2     (input2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUOut     (ALUOut),
    .zero       (zero),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference behaviour written from the opcode table.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.op  = op;
    e.r   = '0;
    e.v   = 1'b0;
    e.lat = 1;
    case (op)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b1100: e.r = ~(a | b);
      4'b0010: begin
        e.r = a + b;
        e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      4'b0110: begin
        e.r = a - b;
        e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      4'b0111: e.r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1000: e.r = (a < b) ? 1 : 0;
      4'b0011: e.r = a << b[4:0];
      4'b0100: e.r = a >> b[4:0];
      4'b0101: e.r = $signed(a) >>> b[4:0];
      4'b1001: begin e.r = a * b; e.lat = W + 1; end
      4'b1010: begin e.r = (b == 0) ? '1 : a / b; e.lat = W + 1; end
      4'b1011: begin e.r = (b == 0) ? a : a % b; e.lat = W + 1; end
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    check("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
    ALUControl = op;
    input1     = a;
    input2     = b;
    in_valid   = 1'b1;
    sb.push_back(model(op, a, b));
    @(posedge clock); #1;
    in_valid = 1'b0;
    // scramble inputs: the DUT must use the latched operands
    ALUControl = 4'($urandom);
    input1     = $urandom;
    input2     = $urandom;
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int cycles = 0;
    int ready_seen = 0;
    logic [W-1:0] held;
    while (!out_valid && cycles < 200) begin
      @(posedge clock); #1;
      cycles++;
      if (!out_valid && in_ready) ready_seen++;
    end
    e = sb.pop_front();
    check("latency", 64'(cycles), 64'(e.lat));
    check("in_ready_low_while_busy", 64'(ready_seen), 64'd0);
    check($sformatf("result_op%0h", e.op), {32'd0, ALUOut}, {32'd0, e.r});
    check($sformatf("zero_op%0h", e.op), {63'd0, zero}, {63'd0, e.z});
    check($sformatf("ovf_op%0h", e.op), {63'd0, overflow}, {63'd0, e.v});
    held = ALUOut;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_result", {32'd0, ALUOut}, {32'd0, held});
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("out_valid_after_accept", {63'd0, out_valid}, 64'd0);
    check("in_ready_after_accept", {63'd0, in_ready}, 64'd1);
    $display("op=%h result=%h zero=%b ovf=%b latency=%0d", e.op, ALUOut, zero, overflow, cycles);
  endtask

  task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    issue(op, a, b);
    collect(hold);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ALUControl = '0;
    input1     = '0;
    input2     = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_ALUOut", {32'd0, ALUOut}, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);   // ADD overflow
    run(4'b0110, 32'd5, 32'd5, 0);                    // SUB -> zero
    run(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);            // SLT signed
    run(4'b1000, 32'hFFFF_FFFF, 32'd1, 0);            // SLTU
    run(4'b0110, 32'h8000_0000, 32'd1, 0);            // SUB overflow
    run(4'b1001, 32'h0001_0003, 32'h0000_0010, 0);    // MUL
    run(4'b1001, 32'd0, 32'h1234_5678, 0);            // MUL by 0, full latency
    run(4'b1010, 32'd100, 32'd7, 0);                  // DIVU
    run(4'b1011, 32'd100, 32'd7, 0);                  // REMU
    run(4'b1010, 32'd9, 32'd0, 0);                    // DIVU by 0
    run(4'b1011, 32'd9, 32'd0, 0);                    // REMU by 0
    run(4'b0101, 32'h8000_0000, 32'd4, 10);           // SRA with backpressure
    run(4'b0100, 32'hF000_0000, 32'h0000_0024, 0);    // SRL, upper shamt bits ignored
    run(4'b0011, 32'h0000_0001, 32'd31, 0);           // SLL max shift
    run(4'b0001, 32'hF000_000F, 32'h0F00_00F0, 0);    // OR
    run(4'b1100, 32'hF000_000F, 32'h0F00_00F0, 0);    // NOR
    run(4'b1101, 32'h1234_5678, 32'h1, 0);            // undefined opcode
    for (int i = 0; i < 6; i++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 12));
      run(rop, $urandom, (i == 0) ? 32'd0 : $urandom, 0);
    end

    // Reset mid-DIVU.
    issue(4'b1010, 32'd1000, 32'd3);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_ALUOut", {32'd0, ALUOut}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    void'(sb.pop_front());
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("postrst_in_ready", {63'd0, in_ready}, 64'd1);
    run(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 0);    // AND after reset

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor of the single-cycle datapath ALU.
- Adds:
  - a configurable operand width;
  - signed/unsigned compare and shifts;
  - iterative multiply, divide and remainder;
  - a registered result with zero and overflow flags.
- Sits in the execute stage between the register-file/immediate mux and the writeback mux.
- The execute stage stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand and result width in bits (≥ 4, power of 2).
- OP_W, 4, ALU control opcode width.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  block can accept an operation.
- ALUControl  input  OP_W  operation select.
- input1  input  WIDTH  operand A.
- input2  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- ALUOut  output  WIDTH  registered result.
- zero  output  1  ALUOut == 0, registered with the result.
- overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops.

Behaviour:
Opcodes:
- 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR.
- 0111 SLT (signed), 1000 SLTU.
- 0011 SLL, 0100 SRL, 0101 SRA.
- 1001 MUL (low WIDTH bits), 1010 DIVU, 1011 REMU.
- Any other code: result 0, zero=1, overflow=0.

Arithmetic and width rules:
- ADD/SUB wrap modulo 2^WIDTH.
- overflow = operand signs equal (ADD) or differ (SUB), and the result sign differs from A.
- Shift amount = input2[$clog2(WIDTH)-1:0]; upper bits are ignored.
- SLT/SLTU produce 0 or 1, zero-extended.

FSM states:
- IDLE: in_ready=1. On in_valid, latch the op and operands.
  - Simple op: compute, go to DONE.
  - MUL/DIVU/REMU: load the iteration counter = WIDTH, go to BUSY.
- BUSY: one shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle; counter decrements. When the counter reaches 0, register the result and flags, go to DONE.
- DONE: out_valid=1. ALUOut, zero and overflow are held stable until out_ready. On out_ready, go to IDLE.

Handshake and latency:
- in_ready=1 only in IDLE; no new operation is accepted while BUSY or DONE.
- Accept at edge k:
  - simple op: out_valid high after edge k+1;
  - MUL/DIVU/REMU: out_valid high after edge k+WIDTH+1.
- out_valid and out_ready high on the same edge → that edge returns to IDLE; in_ready is high the following cycle (no back-to-back acceptance in DONE).

Boundary conditions:
- DIVU by 0: quotient = all ones, no trap.
- REMU by 0: remainder = input1, no trap.
- MUL with either operand 0 still takes the full WIDTH cycles; latency is fixed and data-independent.
- Input changes while BUSY/DONE have no effect; operands are latched at acceptance.

Reset:
- Asynchronous reset at any time, including mid-BUSY, forces IDLE, aborts the operation and clears the counter.
- Reset values: ALUOut=0, zero=0, overflow=0, out_valid=0.
- in_ready=1 once reset is asserted and while it is held.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode constants (ALU_AND … ALU_REMU);
  - the FSM state enum (S_IDLE, S_BUSY, S_DONE).
- One natural sub-module, seq_muldiv, holds the iterative multiplier/divider datapath and counter. It has start, op and operand inputs plus done and result outputs.
- Simple ops stay inline in seq_alu.

Test Plan:
- ADD 0x7FFFFFFF + 1 accepted with out_ready=1 → out_valid one cycle later; ALUOut=0x80000000, overflow=1, zero=0.
- SUB 5−5 then SLT 0xFFFFFFFF vs 1 → first result 0 with zero=1; second result 1. SLTU on the same operands → 0.
- MUL 0x0001_0003 × 0x0000_0010 → out_valid exactly 33 cycles after acceptance; ALUOut=0x0010_0030. in_ready=0 throughout.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- Backpressure: hold out_ready=0 for 10 cycles after SRA 0x80000000>>4 → ALUOut stays 0xF8000000 with out_valid=1 and in_ready=0. Release → IDLE next cycle.
- Assert reset 10 cycles into a DIVU → immediately out_valid=0 and ALUOut=0. After release, in_ready=1, and a new AND 0xF0F0 & 0x0FF0 returns 0x00F0.
